// File: rtl/instr_mem_sync_if.sv
// Fetch and program-load bus of the synchronous instruction memory.
// The core/loader side uses master, the memory uses slave.
interface instr_mem_sync_if #(
    parameter int IDX_W = 8
) ();
    logic             fetch_en;
    logic             stall;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             instr_valid;
    logic             misaligned;
    logic             out_of_range;
    logic             prog_mode;
    logic             prog_we;
    logic [IDX_W-1:0] prog_addr;
    logic [31:0]      prog_data;
    logic [15:0]      prog_count;
    logic             loading;

    modport master (
        output fetch_en, stall, pc, prog_mode, prog_we, prog_addr, prog_data,
        input  instr, instr_valid, misaligned, out_of_range, prog_count, loading
    );

    modport slave (
        input  fetch_en, stall, pc, prog_mode, prog_we, prog_addr, prog_data,
        output instr, instr_valid, misaligned, out_of_range, prog_count, loading
    );
endinterface

// File: rtl/instr_mem_sync.sv
// Word-addressed instruction memory with one-cycle registered fetch, stall hold,
// fault flags and a run-time program-load port (RUN -> PROG -> FLUSH -> RUN).
module instr_mem_sync #(
    parameter int          DEPTH         = 256,
    parameter int          IDX_W         = $clog2(DEPTH),
    parameter logic [31:0] DEFAULT_INSTR = 32'h0800_0000
) (
    input  logic              clk,
    input  logic              reset,
    instr_mem_sync_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PROG  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Words are stored XORed with DEFAULT_INSTR so a zero power-up array reads
    // back as DEFAULT_INSTR; reset never touches the array.
    logic [31:0] mem_q [DEPTH];

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic        oor_q, oor_d;
    logic [15:0] count_q, count_d;
    logic        loading_q, loading_d;

    logic             mem_we_s;
    logic [31:0]      mem_wdata_s;
    logic [IDX_W-1:0] pc_idx_s;
    logic             pc_oor_s;
    logic             pc_mis_s;
    logic [31:0]      rd_word_s;

    assign pc_idx_s    = bus.pc[IDX_W+1:2];
    assign pc_oor_s    = |bus.pc[31:IDX_W+2];
    assign pc_mis_s    = (bus.pc[1:0] != 2'b00);
    assign rd_word_s   = mem_q[pc_idx_s] ^ DEFAULT_INSTR;
    assign mem_wdata_s = bus.prog_data ^ DEFAULT_INSTR;

    // Next-state and next-output logic for the fetch/load controller.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        mis_d    = mis_q;
        oor_d    = oor_q;
        count_d  = count_q;
        mem_we_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.prog_mode) begin
                    state_d = ST_PROG;
                    valid_d = 1'b0;
                    count_d = 16'h0000;
                end else if (bus.fetch_en && !bus.stall) begin
                    valid_d = 1'b1;
                    if (pc_mis_s) begin
                        instr_d = DEFAULT_INSTR;
                        mis_d   = 1'b1;
                        oor_d   = 1'b0;
                    end else if (pc_oor_s) begin
                        instr_d = DEFAULT_INSTR;
                        mis_d   = 1'b0;
                        oor_d   = 1'b1;
                    end else begin
                        instr_d = rd_word_s;
                        mis_d   = 1'b0;
                        oor_d   = 1'b0;
                    end
                end else if (bus.stall) begin
                    valid_d = valid_q;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_PROG: begin
                valid_d = 1'b0;
                if (bus.prog_we) begin
                    mem_we_s = 1'b1;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
                if (!bus.prog_mode) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_PROG;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
                valid_d = 1'b0;
            end
        endcase
        loading_d = (state_d != ST_RUN);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            instr_q   <= 32'h0000_0000;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
            oor_q     <= 1'b0;
            count_q   <= 16'h0000;
            loading_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
            oor_q     <= oor_d;
            count_q   <= count_d;
            loading_q <= loading_d;
        end
    end

    // Program-load write port.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[bus.prog_addr] <= mem_wdata_s;
        end
    end

    assign bus.instr        = instr_q;
    assign bus.instr_valid  = valid_q;
    assign bus.misaligned   = mis_q;
    assign bus.out_of_range = oor_q;
    assign bus.prog_count   = count_q;
    assign bus.loading      = loading_q;
endmodule

// File: tb/tb_instr_mem_sync.sv
// Scenario bench for instr_mem_sync: directed test-plan scenarios plus a randomized
// load/fetch phase, all checked against a word-array reference model.
module tb_instr_mem_sync;
    localparam int          DEPTH = 256;
    localparam int          IDX_W = 8;
    localparam logic [31:0] DEF   = 32'h0800_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    instr_mem_sync_if #(.IDX_W(IDX_W)) bus ();

    instr_mem_sync #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DEFAULT_INSTR(DEF)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [DEPTH];
    int          model_count;
    logic [34:0] exp_out;   // {instr, valid, misaligned, out_of_range}
    logic [34:0] obs;

    assign obs = {bus.instr, bus.instr_valid, bus.misaligned, bus.out_of_range};

    function automatic logic [33:0] ref_fetch(input logic [31:0] pc);
        logic [31:0] widx;
        widx = pc >> 2;
        if (pc % 32'd4 != 32'd0)       return {DEF, 2'b10};
        else if (widx >= 32'(DEPTH))   return {DEF, 2'b01};
        else                           return {model_mem[widx[IDX_W-1:0]], 2'b00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fetch_en  = 1'b0;
        bus.stall     = 1'b0;
        bus.pc        = 32'h0;
        bus.prog_mode = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = 32'h0;
    endtask

    // One RUN-state cycle; updates the expected output from the fetch rules.
    task automatic drive_run(input logic fe, input logic st, input logic [31:0] pc);
        logic [33:0] r;
        bus.fetch_en = fe;
        bus.stall    = st;
        bus.pc       = pc;
        tick();
        r = ref_fetch(pc);
        if (fe && !st)  exp_out = {r[33:2], 1'b1, r[1:0]};
        else if (!st)   exp_out[2] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] pcs [3];
        pcs = '{32'h0, 32'h4, 32'h8};
        idle();
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({obs, bus.prog_count, bus.loading} !== {35'h0, 16'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: got %h/%h/%b want 0/0/0", obs, bus.prog_count, bus.loading);
        end
        exp_out = 35'h0;
        model_count = 0;
        tick();
        tick();
        rst_n = 1'b1;
        foreach (pcs[i]) begin
            drive_run(1'b1, 1'b0, pcs[i]);
            n_checks++;
            if (obs !== {DEF, 3'b100}) begin
                n_errors++;
                $display("FAIL init_fetch pc=%h: got %h want %h", pcs[i], obs, {DEF, 3'b100});
            end
        end
    endtask

    task automatic test_load_run();
        logic [31:0] words [3];
        words = '{32'h3c11_4000, 32'h2631_0004, 32'h2410_00aa};
        idle();
        bus.prog_mode = 1'b1;
        tick();
        exp_out[2] = 1'b0;
        model_count = 0;
        n_checks++;
        if ({bus.loading, bus.prog_count, bus.instr_valid} !== {1'b1, 16'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL prog_entry: got %b/%h/%b want 1/0000/0", bus.loading, bus.prog_count, bus.instr_valid);
        end
        foreach (words[i]) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = IDX_W'(i);
            bus.prog_data = words[i];
            tick();
            model_mem[i] = words[i];
            model_count++;
        end
        bus.prog_we   = 1'b0;
        bus.prog_mode = 1'b0;
        tick();
        n_checks++;
        if ({bus.loading, bus.prog_count, bus.instr_valid} !== {1'b1, 16'(model_count), 1'b0}) begin
            n_errors++;
            $display("FAIL flush_state: got %b/%h/%b want 1/%h/0", bus.loading, bus.prog_count, bus.instr_valid, 16'(model_count));
        end
        bus.fetch_en = 1'b1;
        bus.pc       = 32'h0;
        tick();
        n_checks++;
        if ({bus.loading, bus.instr_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL flush_no_fetch: got loading=%b valid=%b want 0/0", bus.loading, bus.instr_valid);
        end
        foreach (words[i]) begin
            drive_run(1'b1, 1'b0, 32'(4 * i));
            n_checks++;
            if (obs !== {words[i], 3'b100}) begin
                n_errors++;
                $display("FAIL load_run idx%0d: got %h want %h", i, obs, {words[i], 3'b100});
            end
        end
    endtask

    task automatic test_stall();
        drive_run(1'b1, 1'b0, 32'h4);
        n_checks++;
        if (obs !== {32'h2631_0004, 3'b100}) begin
            n_errors++;
            $display("FAIL stall_pre: got %h want %h", obs, {32'h2631_0004, 3'b100});
        end
        for (int i = 0; i < 3; i++) begin
            drive_run(1'b1, 1'b1, 32'h8);
            n_checks++;
            if (obs !== {32'h2631_0004, 3'b100}) begin
                n_errors++;
                $display("FAIL stall_hold%0d: got %h want %h", i, obs, {32'h2631_0004, 3'b100});
            end
        end
        drive_run(1'b1, 1'b0, 32'h8);
        n_checks++;
        if (obs !== {32'h2410_00aa, 3'b100}) begin
            n_errors++;
            $display("FAIL stall_release: got %h want %h", obs, {32'h2410_00aa, 3'b100});
        end
    endtask

    task automatic test_faults();
        logic [31:0] pcs  [4];
        logic [34:0] want [4];
        pcs  = '{32'h0000_0402, 32'h0000_0400, 32'h0000_03FC, 32'h0000_0406};
        want = '{{DEF, 3'b110}, {DEF, 3'b101}, {DEF, 3'b100}, {DEF, 3'b110}};
        foreach (pcs[i]) begin
            drive_run(1'b1, 1'b0, pcs[i]);
            n_checks++;
            if (obs !== want[i] || obs !== exp_out) begin
                n_errors++;
                $display("FAIL fault pc=%h: got %h want %h", pcs[i], obs, want[i]);
            end
        end
        drive_run(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (obs !== {DEF, 3'b010}) begin
            n_errors++;
            $display("FAIL idle_drop_valid: got %h want %h", obs, {DEF, 3'b010});
        end
    endtask

    task automatic test_mode_edges();
        bus.prog_we   = 1'b1;
        bus.prog_addr = IDX_W'(5);
        bus.prog_data = 32'hDEAD_BEEF;
        drive_run(1'b0, 1'b0, 32'h0);
        bus.prog_we = 1'b0;
        n_checks++;
        if (bus.prog_count !== 16'(model_count)) begin
            n_errors++;
            $display("FAIL run_we_count: got %h want %h", bus.prog_count, 16'(model_count));
        end
        drive_run(1'b1, 1'b0, 32'h14);
        n_checks++;
        if (obs !== exp_out) begin
            n_errors++;
            $display("FAIL run_we_ignored: got %h want %h", obs, exp_out);
        end
        bus.fetch_en  = 1'b0;
        bus.prog_mode = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = IDX_W'(6);
        bus.prog_data = 32'h1234_5678;
        tick();
        exp_out[2]  = 1'b0;
        model_count = 0;
        bus.prog_we  = 1'b0;
        bus.fetch_en = 1'b1;
        bus.pc       = 32'h0;
        tick();
        n_checks++;
        if ({bus.instr_valid, bus.prog_count} !== {1'b0, 16'h0}) begin
            n_errors++;
            $display("FAIL prog_fetch_ignored: got valid=%b count=%h want 0/0000", bus.instr_valid, bus.prog_count);
        end
        bus.fetch_en  = 1'b0;
        bus.prog_mode = 1'b0;
        tick();
        tick();
        drive_run(1'b1, 1'b0, 32'h18);
        n_checks++;
        if (obs !== {model_mem[6], 3'b100}) begin
            n_errors++;
            $display("FAIL entry_write_ignored: got %h want %h", obs, {model_mem[6], 3'b100});
        end
    endtask

    task automatic test_reset_mid_load();
        idle();
        bus.prog_mode = 1'b1;
        tick();
        for (int i = 10; i < 12; i++) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = IDX_W'(i);
            bus.prog_data = $urandom;
            tick();
            model_mem[i] = bus.prog_data;
        end
        bus.prog_we   = 1'b0;
        bus.prog_mode = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_out = 35'h0;
        model_count = 0;
        n_checks++;
        if ({obs, bus.prog_count, bus.loading} !== {35'h0, 16'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL mid_load_reset: got %h/%h/%b want 0/0/0", obs, bus.prog_count, bus.loading);
        end
        #2 rst_n = 1'b1;
        tick();
        for (int i = 10; i < 12; i++) begin
            drive_run(1'b1, 1'b0, 32'(4 * i));
            n_checks++;
            if (obs !== {model_mem[i], 3'b100}) begin
                n_errors++;
                $display("FAIL mid_load_kept idx%0d: got %h want %h", i, obs, {model_mem[i], 3'b100});
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic        fe, st;
        idle();
        bus.prog_mode = 1'b1;
        tick();
        exp_out[2]  = 1'b0;
        model_count = 0;
        for (int i = 0; i < 24; i++) begin
            bus.prog_we   = ($urandom_range(0, 1) == 1);
            bus.prog_addr = IDX_W'($urandom_range(0, DEPTH - 1));
            bus.prog_data = $urandom;
            tick();
            if (bus.prog_we) begin
                model_mem[bus.prog_addr] = bus.prog_data;
                model_count++;
            end
        end
        bus.prog_we   = 1'b0;
        bus.prog_mode = 1'b0;
        tick();
        n_checks++;
        if (bus.prog_count !== 16'(model_count)) begin
            n_errors++;
            $display("FAIL rand_count: got %h want %h", bus.prog_count, 16'(model_count));
        end
        tick();
        for (int i = 0; i < 60; i++) begin
            fe = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 9))
                0:       pc = {$urandom_range(0, 1023) , 2'b00} | 32'($urandom_range(1, 3));
                1:       pc = 32'h400 + {$urandom_range(0, 4095), 2'b00};
                default: pc = {$urandom_range(0, DEPTH - 1), 2'b00};
            endcase
            drive_run(fe, st, pc);
            n_checks++;
            if (obs !== exp_out) begin
                n_errors++;
                $display("FAIL rand_fetch%0d pc=%h fe=%b st=%b: got %h want %h", i, pc, fe, st, obs, exp_out);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = DEF;
        test_reset();
        test_load_run();
        test_stall();
        test_faults();
        test_mode_edges();
        test_reset_mid_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Parametrised, synchronous instruction memory for the pipelined MIPS core; replaces the fixed 32-entry combinational instruction ROM. It provides a word-addressed fetch port with one-cycle registered latency, stall hold, and alignment/range checking. It also has a program-load port, driven by the UART boot loader, that rewrites the contents at run time. It sits between the PC/IF stage and the IF/ID pipeline register.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; must be a power of two, at least 2.
- IDX_W, $clog2(DEPTH): word-index width (derived).
- DEFAULT_INSTR, 32'h0800_0000: word returned for misaligned or out-of-range fetches (j 0). Also the initial content of every word.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_en  in  1  fetch request for pc this cycle.
- stall  in  1  hold the current fetch output; overrides fetch_en.
- pc  in  32  byte address of the instruction.
- instr  out  32  fetched instruction.
- instr_valid  out  1  instr holds the result of an accepted fetch.
- misaligned  out  1  accepted fetch had pc[1:0] != 0.
- out_of_range  out  1  accepted fetch had pc[31:2] >= DEPTH.
- prog_mode  in  1  request program-load mode.
- prog_we  in  1  write strobe; honoured only in PROG state.
- prog_addr  in  IDX_W  word index to write.
- prog_data  in  32  word to write.
- prog_count  out  16  writes accepted since the last entry to PROG; saturates at 16'hFFFF.
- loading  out  1  high while the state is PROG or FLUSH.

## Operation
- Storage: DEPTH x 32 array, initialised to DEFAULT_INSTR. The array is not cleared by reset.
- FSM states and transitions:
  - RUN: fetches are served. prog_mode=1 moves to PROG.
  - PROG: fetches are ignored; writes are accepted. prog_mode=0 moves to FLUSH.
  - FLUSH: lasts exactly one cycle, then moves to RUN. No fetch is accepted and no write is accepted.
- Accepted fetch: state RUN, fetch_en=1 and stall=0.
  - If pc[1:0] != 0: instr=DEFAULT_INSTR, misaligned=1.
  - Else if pc[31:2] >= DEPTH: instr=DEFAULT_INSTR, out_of_range=1.
  - Else: instr=mem[pc[IDX_W+1:2]], both flags 0.
  - Misaligned takes priority when both conditions hold.
  - instr_valid=1.
- No accepted fetch and stall=1: instr, instr_valid and both flags hold their values.
- No accepted fetch and stall=0: instr_valid=0. instr and the flags hold their values.
- On transition into PROG, or while in PROG or FLUSH: instr_valid=0.
- Write: state PROG and prog_we=1 stores mem[prog_addr]=prog_data and increments prog_count (saturating). prog_count clears to 0 on the RUN->PROG edge.
- A write in the same cycle as the PROG entry edge is ignored.
- prog_we outside PROG is ignored and prog_count is unchanged.

## Timing
- Reset (reset=0, asynchronous) sets:
  - state = RUN
  - instr = 32'h0000_0000
  - instr_valid = 0, misaligned = 0, out_of_range = 0
  - prog_count = 0, loading = 0
  - The array is unaffected.
- Fetch latency: pc sampled at edge N gives instr/instr_valid/flags valid after edge N; back-to-back fetches give one result per cycle.
- Stall takes priority over fetch_en. The value presented before the stall is held for as long as stall=1.
- prog_mode=1 sampled at edge N: loading=1 and instr_valid=0 after edge N.
- prog_mode=0 sampled at edge M: FLUSH after edge M, RUN after edge M+1. The first fetch is accepted at edge M+2.
- Write then read of the same word: a write at edge W is visible to any fetch accepted at or after the first RUN edge. Writes and fetches never overlap in time.
- Asserting reset mid-PROG aborts the load. Words already written remain; prog_count clears to 0.
- Wrap: pc=4*(DEPTH-1) is in range. pc=4*DEPTH is out_of_range.

## Test plan
- Reset then initial contents: reset low then high, fetch pc=0, 4, 8 -> instr_valid=1 one cycle later, each instr=32'h0800_0000, flags 0.
- Load and run: prog_mode=1; write idx0=32'h3c11_4000, idx1=32'h2631_0004, idx2=32'h2410_00aa; prog_mode=0 -> prog_count=3, loading high through FLUSH. Fetches at pc=0, 4, 8 from edge M+2 return those words in order on consecutive cycles.
- Stall: fetch pc=4 (instr 32'h2631_0004), then stall=1 for 3 cycles with pc=8 -> instr and instr_valid held. Release -> 32'h2410_00aa next cycle.
- Faults (DEPTH=256): pc=32'h0000_0402 -> misaligned=1, instr=DEFAULT_INSTR. pc=32'h0000_0400 -> out_of_range=1. pc=32'h0000_03FC -> in range, flags 0.
- Mode edges: prog_we=1 in RUN -> no write, prog_count unchanged. fetch_en=1 during PROG -> instr_valid stays 0.
- Reset mid-load: write 2 words, assert reset -> prog_count=0, state RUN. Fetches of the 2 written words return their new values.
